// File: rtl/tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg
// Shared definitions for the TX frame scheduler: the FSM state encoding and
// the default timing/width constants used as parameter defaults by
// tx_frame_sched.
// ---------------------------------------------------------------------------
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    SEND,
    GAP
  } sched_state_t;

  localparam int TXD_NUM_DEF     = 12;     // frame payload width
  localparam int GAP_CYC_DEF     = 40;     // idle cycles between frames
  localparam int REFRESH_CYC_DEF = 20000;  // 1 ms of line silence at 20 MHz
  localparam int START_TO_DEF    = 16;     // cycles allowed for tx_busy to rise

endpackage

// File: rtl/tx_frame_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin selection among requesters 1..N_REQ-1. Requester 0 is never
// considered here; its absolute priority is applied by the caller.
// Ports:
//   req    - request vector (bit 0 ignored)
//   ptr    - index where the search starts (1..N_REQ-1)
//   winner - one-hot winner, all zeros when no requester 1..N_REQ-1 is high
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the ring starting at ptr; index wraps from N_REQ-1 back to 1 so the
  // emergency requester is never visited.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < N_REQ - 1; k++) begin
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
      idx = (idx == PW'(N_REQ - 1)) ? PW'(1) : idx + PW'(1);
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// ---------------------------------------------------------------------------
// tx_frame_sched
// Arbitrates payload requests onto a single Manchester transmitter, enforces
// an inter-frame gap, re-sends the last frame after a period of line silence
// and flags a transmitter that never starts.
// Ports:
//   clk_20M     - 20 MHz clock
//   reset_n     - asynchronous active-low reset
//   req         - level requests, held until granted (bit 0 = emergency)
//   req_data    - packed payloads, slice i belongs to req[i]
//   gnt         - one-cycle grant pulse, payload captured in that cycle
//   tx_en       - one-cycle launch strobe to the transmitter
//   data_out    - registered payload presented to the transmitter
//   tx_busy     - transmitter busy level
//   sched_busy  - high whenever the scheduler is not idle
//   timeout_err - sticky: tx_busy failed to rise after a launch
// ---------------------------------------------------------------------------
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int TXD_NUM     = TXD_NUM_DEF,
  parameter int N_REQ       = 4,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int REFRESH_CYC = REFRESH_CYC_DEF,
  parameter int START_TO    = START_TO_DEF
) (
  input  logic                     clk_20M,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*TXD_NUM-1:0] req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     tx_en,
  output logic [TXD_NUM-1:0]       data_out,
  input  logic                     tx_busy,
  output logic                     sched_busy,
  output logic                     timeout_err
);

  localparam int PW      = $clog2(N_REQ);
  localparam int CNT_MAX = (GAP_CYC > START_TO) ? GAP_CYC : START_TO;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam int RW      = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);

  sched_state_t       state, next_state;
  logic [PW-1:0]      rr_ptr, rr_ptr_next;
  logic [N_REQ-1:0]   rr_winner, sel_vec;
  logic [TXD_NUM-1:0] sel_data;
  logic [CW-1:0]      cnt;
  logic [RW-1:0]      ref_cnt;
  logic               last_valid;
  logic               launch_gnt, set_timeout;
  logic               gap_done, wait_done;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (rr_winner)
  );

  // Emergency requester overrides the round-robin choice outright.
  assign sel_vec = req[0] ? N_REQ'(1) : rr_winner;

  // Payload mux for the selected requester and the pointer that follows a
  // round-robin grant; an emergency grant leaves the pointer where it was.
  always_comb begin
    sel_data    = '0;
    rr_ptr_next = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_vec[i]) sel_data = req_data[i*TXD_NUM +: TXD_NUM];
    end
    for (int i = 1; i < N_REQ; i++) begin
      if (rr_winner[i] && !req[0]) rr_ptr_next = (i == N_REQ - 1) ? PW'(1) : PW'(i + 1);
    end
  end

  // GAP_CYC = 0 still spends one cycle in GAP.
  assign gap_done  = (int'(cnt) + 1 >= GAP_CYC);
  assign wait_done = (int'(cnt) + 1 >= START_TO);

  always_comb begin
    next_state  = state;
    gnt         = '0;
    launch_gnt  = 1'b0;
    set_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        // A pending request always beats a due refresh.
        if (|req) begin
          gnt        = sel_vec;
          launch_gnt = 1'b1;
          next_state = LAUNCH;
        end else if (last_valid && ref_cnt == REF_LAST) begin
          next_state = LAUNCH;
        end
      end
      LAUNCH:    next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          next_state = SEND;
        end else if (wait_done) begin
          set_timeout = 1'b1;
          next_state  = GAP;
        end
      end
      SEND:      if (!tx_busy) next_state = GAP;
      GAP:       if (gap_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_20M or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= PW'(1);
      data_out    <= '0;
      last_valid  <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
      ref_cnt     <= '0;
    end else begin
      state <= next_state;

      // Shared timer for WAIT_BUSY and GAP, restarted on every state change.
      if (state != next_state || !(state inside {WAIT_BUSY, GAP})) cnt <= '0;
      else                                                         cnt <= cnt + 1'b1;

      if (launch_gnt) begin
        data_out   <= sel_data;
        last_valid <= 1'b1;
        rr_ptr     <= rr_ptr_next;
      end

      if (set_timeout) timeout_err <= 1'b1;

      // Silence timer only runs while idle and saturates at its terminal value.
      if (tx_en || (state == IDLE && next_state == LAUNCH)) ref_cnt <= '0;
      else if (state == IDLE && ref_cnt != REF_LAST)       ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign tx_en      = (state == LAUNCH);
  assign sched_busy = (state != IDLE);

endmodule

// File: tb/tb_tx_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_sched
// Directed bench for tx_frame_sched with an expected-frame queue: each
// expected launch (grant index, payload) is queued when stimulus is driven
// and checked when the DUT raises tx_en.
// ---------------------------------------------------------------------------
module tb_tx_frame_sched;

  localparam int TXD_NUM     = 12;
  localparam int N_REQ       = 4;
  localparam int GAP_CYC     = 40;
  localparam int REFRESH_CYC = 20000;
  localparam int START_TO    = 16;

  typedef struct {
    int                 gnt_idx;  // -1 means a refresh launch with no grant
    logic [TXD_NUM-1:0] data;
    bit                 chk_lat;
  } exp_t;

  logic                     clk_20M  = 1'b0;
  logic                     reset_n  = 1'b0;
  logic                     tx_busy  = 1'b0;
  logic                     tx_dead  = 1'b0;
  logic [N_REQ-1:0]         req      = '0;
  logic [N_REQ*TXD_NUM-1:0] req_data = '0;
  logic [N_REQ-1:0]         gnt;
  logic                     tx_en;
  logic [TXD_NUM-1:0]       data_out;
  logic                     sched_busy;
  logic                     timeout_err;

  exp_t               sb_q[$];
  int                 checks   = 0;
  int                 errors   = 0;
  int                 cyc      = 0;
  int                 seen_gnt = -1;
  int                 fall_cyc = 0;
  logic               busy_q   = 1'b0;
  logic               in_frame = 1'b0;
  logic [TXD_NUM-1:0] cur_data = '0;

  tx_frame_sched #(
    .TXD_NUM     (TXD_NUM),
    .N_REQ       (N_REQ),
    .GAP_CYC     (GAP_CYC),
    .REFRESH_CYC (REFRESH_CYC),
    .START_TO    (START_TO)
  ) dut (
    .clk_20M     (clk_20M),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .tx_en       (tx_en),
    .data_out    (data_out),
    .tx_busy     (tx_busy),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  always #25 clk_20M = ~clk_20M;

  always @(posedge clk_20M) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [N_REQ-1:0] r);
    @(posedge clk_20M);
    #1 req = r;
  endtask

  task automatic set_slice(input int i, input logic [TXD_NUM-1:0] v);
    req_data[i*TXD_NUM +: TXD_NUM] = v;
  endtask

  task automatic push_exp(input int idx, input logic [TXD_NUM-1:0] d, input bit lat);
    exp_t e;
    e.gnt_idx = idx;
    e.data    = d;
    e.chk_lat = lat;
    sb_q.push_back(e);
  endtask

  // Requester behaviour: keep the request until its grant, then drop it.
  task automatic wait_grant_drop(input string tag, input int max_cycles);
    logic [N_REQ-1:0] g = '0;
    bit got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk_20M);
      if (gnt != '0) begin
        g   = gnt;
        got = 1'b1;
      end
    end
    check_output(tag, 32'(got), 32'd1);
    if (got) begin
      @(posedge clk_20M);
      #1 req = req & ~g;
    end
  endtask

  task automatic wait_tx_en(input string tag, input int max_cycles, output int at);
    bit got = 1'b0;
    at = -1;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk_20M);
      if (tx_en) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    check_output(tag, 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles, output int at);
    bit got = 1'b0;
    at = -1;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(negedge clk_20M);
      if (sb_q.size() == 0 && !sched_busy) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    check_output(tag, 32'(got), 32'd1);
  endtask

  // Transmitter model: busy rises two cycles after tx_en and lasts ten cycles.
  task automatic transmitter();
    forever begin
      @(negedge clk_20M);
      if (tx_en && !tx_dead) begin
        repeat (2) @(posedge clk_20M);
        #1 tx_busy = 1'b1;
        repeat (10) @(posedge clk_20M);
        #1 tx_busy = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_20M);
      if (!reset_n) begin
        seen_gnt = -1;
        in_frame = 1'b0;
        busy_q   = tx_busy;
      end else begin
        if (busy_q && !tx_busy) begin
          fall_cyc = cyc;
          if (in_frame) begin
            check_output("data_stable", 32'(data_out), 32'(cur_data));
            in_frame = 1'b0;
          end
        end
        busy_q = tx_busy;
        if (gnt != '0) begin
          check_output("gnt_onehot", 32'($onehot(gnt)), 32'd1);
          check_output("one_gnt_per_frame", seen_gnt, -1);
          for (int i = 0; i < N_REQ; i++) if (gnt[i]) seen_gnt = i;
        end
        if (tx_en) begin
          check_output("tx_en_expected", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_output("frame_gnt", seen_gnt, e.gnt_idx);
            check_output("frame_data", 32'(data_out), 32'(e.data));
            if (e.chk_lat) check_output("frame_latency", cyc - fall_cyc, GAP_CYC + 2);
            cur_data = e.data;
          end
          in_frame = 1'b1;
          seen_gnt = -1;
        end
      end
    end
  endtask

  initial begin
    int t_a, t_b;
    bit saw;

    fork
      monitor();
      transmitter();
    join_none

    // Reset values
    repeat (3) @(negedge clk_20M);
    check_output("rst_gnt", 32'(gnt), 32'd0);
    check_output("rst_tx_en", 32'(tx_en), 32'd0);
    check_output("rst_data_out", 32'(data_out), 32'd0);
    check_output("rst_sched_busy", 32'(sched_busy), 32'd0);
    check_output("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk_20M);
    #1 reset_n = 1'b1;

    // Two simultaneous round-robin requests
    $display("[TB] step: req 0110");
    set_slice(1, 12'hA5A);
    set_slice(2, 12'h3C3);
    push_exp(1, 12'hA5A, 1'b0);
    push_exp(2, 12'h3C3, 1'b1);
    apply_stimulus(4'b0110);
    wait_grant_drop("grant_a5a", 50);
    wait_grant_drop("grant_3c3", 200);
    wait_idle("idle_after_pair", 200, t_a);

    // Emergency request raised during GAP overtakes a pending req[3]
    $display("[TB] step: emergency during gap");
    set_slice(1, 12'h111);
    set_slice(3, 12'h777);
    set_slice(0, 12'hFFF);
    push_exp(1, 12'h111, 1'b0);
    push_exp(0, 12'hFFF, 1'b1);
    push_exp(3, 12'h777, 1'b1);
    apply_stimulus(4'b0010);
    wait_grant_drop("grant_111", 50);
    repeat (25) @(posedge clk_20M);
    #1 req = 4'b0100;
    repeat (4) @(posedge clk_20M);
    #1 req = 4'b1000;
    repeat (2) @(posedge clk_20M);
    #1 req = 4'b1001;
    @(negedge clk_20M);
    check_output("still_in_gap", 32'(sched_busy), 32'd1);
    wait_grant_drop("grant_fff", 100);
    wait_grant_drop("grant_777", 200);
    wait_idle("idle_after_emerg", 200, t_a);

    // Continuous requests rotate without starvation
    $display("[TB] step: round-robin rotation");
    set_slice(1, 12'h1A1);
    set_slice(2, 12'h2B2);
    set_slice(3, 12'h3C3);
    for (int k = 0; k < 6; k++) begin
      int idx;
      logic [TXD_NUM-1:0] d;
      idx = (k % 3) + 1;
      d   = (idx == 1) ? 12'h1A1 : (idx == 2) ? 12'h2B2 : 12'h3C3;
      push_exp(idx, d, k != 0);
    end
    apply_stimulus(4'b1110);
    saw = 1'b0;
    for (int i = 0; i < 1000 && !saw; i++) begin
      @(negedge clk_20M);
      if (sb_q.size() == 0) saw = 1'b1;
    end
    check_output("rotation_done", 32'(saw), 32'd1);
    apply_stimulus(4'b0000);
    wait_idle("idle_after_rotation", 200, t_a);

    // Dead transmitter: timeout flag after START_TO waiting cycles
    $display("[TB] step: start timeout");
    tx_dead = 1'b1;
    set_slice(1, 12'h0EE);
    push_exp(1, 12'h0EE, 1'b0);
    apply_stimulus(4'b0010);
    wait_grant_drop("grant_0ee", 50);
    wait_tx_en("tx_en_0ee", 10, t_a);
    repeat (START_TO) @(negedge clk_20M);
    check_output("timeout_not_early", 32'(timeout_err), 32'd0);
    @(negedge clk_20M);
    check_output("timeout_set", 32'(timeout_err), 32'd1);
    wait_idle("idle_after_timeout", 100, t_a);
    check_output("timeout_sticky", 32'(timeout_err), 32'd1);
    tx_dead = 1'b0;

    // Refresh of the last frame after line silence
    $display("[TB] step: refresh");
    set_slice(2, 12'h123);
    push_exp(2, 12'h123, 1'b0);
    apply_stimulus(4'b0100);
    wait_grant_drop("grant_123", 50);
    set_slice(2, 12'h999);
    wait_idle("idle_after_123", 200, t_a);
    push_exp(-1, 12'h123, 1'b0);
    wait_tx_en("refresh_tx_en", REFRESH_CYC + 100, t_b);
    check_output("refresh_delay", t_b - t_a, REFRESH_CYC);
    wait_idle("idle_after_refresh", 200, t_a);

    // Reset in the middle of SEND
    $display("[TB] step: reset mid-frame");
    set_slice(3, 12'h456);
    push_exp(3, 12'h456, 1'b0);
    apply_stimulus(4'b1000);
    wait_grant_drop("grant_456", 50);
    wait_tx_en("tx_en_456", 10, t_a);
    repeat (5) @(negedge clk_20M);
    check_output("in_send", 32'(sched_busy), 32'd1);
    #5 reset_n = 1'b0;
    #1;
    check_output("mid_rst_gnt", 32'(gnt), 32'd0);
    check_output("mid_rst_tx_en", 32'(tx_en), 32'd0);
    check_output("mid_rst_data_out", 32'(data_out), 32'd0);
    check_output("mid_rst_sched_busy", 32'(sched_busy), 32'd0);
    check_output("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (3) @(posedge clk_20M);
    #1 reset_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk_20M);
      if (tx_en || sched_busy) saw = 1'b1;
    end
    check_output("no_refresh_after_reset", 32'(saw), 32'd0);
    check_output("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
